// File: rtl/count_up_timer.sv
// Elapsed-time stopwatch counting mm:ss upward, with binary and BCD seconds outputs.
// Stops at a programmable limit or at MAX_MINUTE:59, whichever comes first.
module count_up_timer #(
   parameter int unsigned TICKS_PER_SEC = 50000000,
   parameter int unsigned MAX_MINUTE    = 9
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       clear_i,
   input  logic [3:0] limit_min_i,
   input  logic [5:0] limit_sec_i,
   output logic [3:0] minute_o,
   output logic [5:0] second_o,
   output logic [2:0] sec_tens_o,
   output logic [3:0] sec_ones_o,
   output logic       running_o,
   output logic       done_o,
   output logic       sec_pulse_o
);

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(TICKS_PER_SEC - 1);
   localparam logic [3:0] MaxMin = 4'(MAX_MINUTE);

   typedef enum logic [1:0] {StIdle, StRunning, StPaused, StDone} state_e;

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic [3:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic [2:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          running_q, done_q, pulse_q;
   logic          term, hit_limit, hit_sat;

   // Candidate post-increment time; only committed on a prescaler terminal count.
   always_comb begin
      term   = (presc_q == PrescMax) && (state_q == StRunning) && !stop_i && !clear_i;
      min_d  = min_q;
      sec_d  = sec_q + 6'd1;
      tens_d = tens_q;
      ones_d = ones_q + 4'd1;
      if (sec_q == 6'd59) begin
         sec_d  = 6'd0;
         min_d  = min_q + 4'd1;
         tens_d = 3'd0;
         ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
         ones_d = 4'd0;
         tens_d = tens_q + 3'd1;
      end
      hit_limit = ({limit_min_i, limit_sec_i} != 10'd0) &&
                  (min_d == limit_min_i) && (sec_d == limit_sec_i);
      hit_sat   = (min_d == MaxMin) && (sec_d == 6'd59);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         min_q     <= 4'd0;
         sec_q     <= 6'd0;
         tens_q    <= 3'd0;
         ones_q    <= 4'd0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (clear_i) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            min_q     <= 4'd0;
            sec_q     <= 6'd0;
            tens_q    <= 3'd0;
            ones_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
         end else begin
            case (state_q)
               StIdle, StPaused: begin
                  if (start_i) begin
                     state_q   <= StRunning;
                     running_q <= 1'b1;
                  end
               end
               StRunning: begin
                  if (term) begin
                     presc_q <= '0;
                     min_q   <= min_d;
                     sec_q   <= sec_d;
                     tens_q  <= tens_d;
                     ones_q  <= ones_d;
                     pulse_q <= 1'b1;
                     if (hit_limit || hit_sat) begin
                        state_q   <= StDone;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                     end
                  end else if (presc_q != PrescMax) begin
                     // Still counts on the stop edge; the fraction is kept for resume.
                     presc_q <= presc_q + PW'(1);
                  end
                  if (stop_i) begin
                     state_q   <= StPaused;
                     running_q <= 1'b0;
                  end
               end
               StDone: ;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign minute_o    = min_q;
   assign second_o    = sec_q;
   assign sec_tens_o  = tens_q;
   assign sec_ones_o  = ones_q;
   assign running_o   = running_q;
   assign done_o      = done_q;
   assign sec_pulse_o = pulse_q;

endmodule

// File: tb/tb_count_up_timer.sv
// Scoreboard bench for count_up_timer: expected time updates are queued by the stimulus
// and checked by a monitor on every sec_pulse; directed checks cover state and priority.
module tb_count_up_timer;

   logic       clk = 1'b0;
   logic       resetn, start, stop, clear;
   logic [3:0] limit_min;
   logic [5:0] limit_sec;
   logic [3:0] minute;
   logic [5:0] second;
   logic [2:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running, done, sec_pulse;

   int vectors = 0;
   int misses  = 0;

   typedef struct {
      int m;
      int s;
      int tens;
      int ones;
      int run;
      int dn;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   count_up_timer #(
      .TICKS_PER_SEC(4),
      .MAX_MINUTE   (1)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (start),
      .stop_i     (stop),
      .clear_i    (clear),
      .limit_min_i(limit_min),
      .limit_sec_i(limit_sec),
      .minute_o   (minute),
      .second_o   (second),
      .sec_tens_o (sec_tens),
      .sec_ones_o (sec_ones),
      .running_o  (running),
      .done_o     (done),
      .sec_pulse_o(sec_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         misses++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int m, input int s, input int run, input int dn);
      exp_q.push_back('{m, s, s / 10, s % 10, run, dn});
   endtask

   task automatic push_run(input int from, input int to);
      for (int t = from; t <= to; t++) push(t / 60, t % 60, 1, 0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic check_time(input string tag, input int m, input int s);
      check({tag, "_min"}, int'(minute), m);
      check({tag, "_sec"}, int'(second), s);
      check({tag, "_tens"}, int'(sec_tens), s / 10);
      check({tag, "_ones"}, int'(sec_ones), s % 10);
   endtask

   task automatic check_zero(input string tag);
      check_time(tag, 0, 0);
      check({tag, "_running"}, int'(running), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_pulse"}, int'(sec_pulse), 0);
   endtask

   // Monitor: every time update must match the next queued expectation.
   always @(negedge clk) begin
      if (resetn === 1'b1 && sec_pulse === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            misses++;
            $display("FAIL unexpected_pulse: got %0d:%0d, expected no update", minute, second);
         end else begin
            mon_e = exp_q.pop_front();
            check("upd_min", int'(minute), mon_e.m);
            check("upd_sec", int'(second), mon_e.s);
            check("upd_tens", int'(sec_tens), mon_e.tens);
            check("upd_ones", int'(sec_ones), mon_e.ones);
            check("upd_running", int'(running), mon_e.run);
            check("upd_done", int'(done), mon_e.dn);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn    = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      clear     = 1'b0;
      limit_min = 4'd0;
      limit_sec = 6'd0;
      step(3);
      check_zero("reset");
      resetn = 1'b1;
      step(1);

      // Count: first update 4 edges after start, 1:00 at edge 240.
      push_run(1, 60);
      pulse_start();
      step(3);
      check("cnt_pre_pulse", int'(sec_pulse), 0);
      check("cnt_pre_sec", int'(second), 0);
      step(1);
      check("cnt_first_pulse", int'(sec_pulse), 1);
      check("cnt_first_sec", int'(second), 1);
      step(236);
      check_time("cnt_240", 1, 0);
      check("cnt_240_running", int'(running), 1);
      pulse_clear();
      check_zero("cnt_clear");

      // BCD carry 0:19 -> 0:20.
      push_run(1, 20);
      pulse_start();
      step(76);
      check_time("bcd_19", 0, 19);
      step(4);
      check_time("bcd_20", 0, 20);
      pulse_clear();

      // Pause keeps the fractional second.
      push_run(1, 2);
      pulse_start();
      step(5);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("pause_running", int'(running), 0);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("pause_hold_sec", int'(second), 1);
      end
      pulse_start();
      check("resume_running", int'(running), 1);
      step(1);
      check("resume_sec_1", int'(second), 1);
      step(1);
      check("resume_sec_2", int'(second), 2);
      pulse_clear();

      // Limit 0:05 reached at edge 20; DONE ignores start.
      limit_min = 4'd0;
      limit_sec = 6'd5;
      push_run(1, 4);
      push(0, 5, 0, 1);
      pulse_start();
      step(19);
      check("lim_pre_done", int'(done), 0);
      step(1);
      check("lim_done", int'(done), 1);
      check("lim_running", int'(running), 0);
      check_time("lim_time", 0, 5);
      pulse_start();
      step(2);
      check("lim_hold_done", int'(done), 1);
      check("lim_hold_running", int'(running), 0);
      check_time("lim_hold", 0, 5);
      pulse_clear();
      check_zero("lim_clear");
      limit_sec = 6'd0;

      // Saturation at 1:59 (edge 476) with no limit.
      push_run(1, 118);
      push(1, 59, 0, 1);
      pulse_start();
      step(475);
      check("sat_pre_done", int'(done), 0);
      step(1);
      check("sat_done", int'(done), 1);
      check_time("sat_time", 1, 59);
      step(8);
      check_time("sat_frozen", 1, 59);
      check("sat_frozen_done", int'(done), 1);
      pulse_clear();

      // clear beats start.
      clear = 1'b1;
      start = 1'b1;
      step(1);
      clear = 1'b0;
      start = 1'b0;
      check("prio_clr_running", int'(running), 0);
      step(6);
      check_time("prio_clr_time", 0, 0);

      // stop beats start while running.
      push(0, 1, 1, 0);
      pulse_start();
      step(4);
      stop  = 1'b1;
      start = 1'b1;
      step(1);
      stop  = 1'b0;
      start = 1'b0;
      check("prio_stop_running", int'(running), 0);
      step(4);
      check_time("prio_stop_hold", 0, 1);

      // Reset mid-run clears everything on the next edge.
      pulse_start();
      check("rst_pre_running", int'(running), 1);
      step(1);
      resetn = 1'b0;
      step(1);
      check_zero("rst_mid");
      resetn = 1'b1;
      step(2);

      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
